// File: rtl/io_input_deglitch.sv
// Pad-input conditioner: synchronises PAD_I to UserCLK, filters out short glitches,
// and produces a clean level, one-cycle rise/fall strobes and a wrapping rising-edge count.
module io_input_deglitch #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_W    = 4,
   parameter int CNT_W       = 8
) (
   input  logic                UserCLK,
   input  logic                resetn,
   input  logic                PAD_I,
   input  logic [FILTER_W:0]   ConfigBits,
   input  logic                CntClr,
   output logic                O,
   output logic                Rise,
   output logic                Fall,
   output logic [CNT_W-1:0]    EdgeCnt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FILTER_W-1:0]    cnt;
   logic [FILTER_W-1:0]    threshold;
   logic [FILTER_W-1:0]    neff;
   logic [FILTER_W:0]      cnt_inc;
   logic                   s;
   logic                   filter_en;
   logic                   commit;
   logic                   rise_commit;
   logic                   fall_commit;

   assign s         = sync_q[SYNC_STAGES-1];
   assign filter_en = ConfigBits[0];
   assign threshold = ConfigBits[FILTER_W:1];

   // A zero threshold and a disabled filter both collapse to the single-cycle case.
   always_comb begin
      neff = threshold;
      if (!filter_en || (threshold == '0)) begin
         neff = FILTER_W'(1);
      end
   end

   // One extra bit so cnt+1 cannot wrap before the compare against neff.
   assign cnt_inc     = {1'b0, cnt} + (FILTER_W+1)'(1);
   assign commit      = (s != O) && (cnt_inc >= {1'b0, neff});
   assign rise_commit = commit && s;
   assign fall_commit = commit && !s;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let the sync chain collapse in one cycle.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         sync_q  <= '0;
         cnt     <= '0;
         O       <= 1'b0;
         Rise    <= 1'b0;
         Fall    <= 1'b0;
         EdgeCnt <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_I};
         Rise   <= rise_commit;
         Fall   <= fall_commit;

         if (s == O) begin
            cnt <= '0;
         end else if (commit) begin
            O   <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt_inc[FILTER_W-1:0];
         end

         // A rise committing on the clearing edge is counted after the clear.
         if (CntClr) begin
            EdgeCnt <= rise_commit ? CNT_W'(1) : '0;
         end else if (rise_commit) begin
            EdgeCnt <= EdgeCnt + CNT_W'(1);
         end
      end
   end

endmodule
